// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access sizes and FSM states.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_t;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling for sub-word accesses: merges store data into
// an existing word and extracts/extends load data from a fetched word.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  logic [31:0] shifted;

  // Replace only the addressed byte or half lane of the old word
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      SZ_WORD: merged = wdata;
      default: merged = word;
    endcase
  end

  // Bring the addressed lane down to bit 0, then sign- or zero-extend it
  always_comb begin
    shifted = word >> {offset, 3'b000};
    loaded  = word;
    case (size)
      SZ_BYTE: loaded = is_unsigned ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: loaded = is_unsigned ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default: loaded = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-addressed memory.
// One request at a time; sub-word stores are read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  state_t      state, next_state;
  logic        accept;
  logic        req_err;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic        write_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] merged_word;
  logic [31:0] load_data;

  assign accept = req_valid && (state == ST_IDLE);

  // Flag misaligned, illegal-size or out-of-range requests at acceptance
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS) req_err = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and per-state outputs; writes are also blocked while in reset
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                           next_state = ST_RESP;
          else if (req_write && req_size == SZ_WORD) next_state = ST_WR;
          else                                   next_state = ST_RD;
        end
      end
      ST_RD: begin
        mem_read   = 1'b1;
        next_state = write_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_write  = rst_n;
        next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Capture the request, build store words and latch load results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else if (accept) begin
      size_q  <= req_size;
      off_q   <= req_addr[1:0];
      uns_q   <= req_unsigned;
      write_q <= req_write;
      err_q   <= req_err;
      wdata_q <= req_wdata;
      rdata_q <= 32'h0;
      if (!req_err) mem_addr_q <= {req_addr[31:2], 2'b00};
      if (!req_err && req_write && req_size == SZ_WORD) mem_wdata_q <= req_wdata;
    end else if (state == ST_RD) begin
      if (write_q) mem_wdata_q <= merged_word;
      else         rdata_q     <= load_data;
    end
  end

  lane_align u_lane_align (
    .word        (mem_rdata),
    .wdata       (wdata_q),
    .size        (size_q),
    .offset      (off_q),
    .is_unsigned (uns_q),
    .merged      (merged_word),
    .loaded      (load_data)
  );

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random
// requests compared against a word-array reference of the memory.
module tb_mem_access_unit;

  localparam int unsigned MEM_WORDS = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem_arr [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        loaded = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Combinational-read memory responder
  assign mem_rdata = (mem_addr[31:2] < MEM_WORDS) ? mem_arr[mem_addr[6:2]] : 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory commit on negedge, plus activity counters
  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] <= ref_mem[i];
      loaded <= 1'b1;
    end else if (mem_write && mem_addr[31:2] < MEM_WORDS) begin
      mem_arr[mem_addr[6:2]] <= mem_wdata;
    end
    if (mem_read)   rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
    if (resp_valid) resp_cnt++;
    if (loaded) checkOutput("rw_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
  end

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
          (size == 2'b10 && addr % 4 != 0) || (addr / 4 >= MEM_WORDS);
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
    logic [31:0] v;
    v = ref_mem[addr / 4] >> (8 * (addr % 4));
    if (size == 2'b00) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (size == 2'b01) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [1:0] size, input logic [31:0] addr,
                                              input logic [31:0] wdata);
    logic [31:0] mask;
    logic [31:0] old;
    old = ref_mem[addr / 4];
    if (size == 2'b10) return wdata;
    mask = (size == 2'b00) ? 32'hFF : 32'hFFFF;
    return (old & ~(mask << (8 * (addr % 4)))) | ((wdata & mask) << (8 * (addr % 4)));
  endfunction

  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    int          rd0;
    int          wr0;
    int          lat;
    logic        got;
    logic        got_err;
    logic [31:0] got_rdata;

    exp_err   = model_err(size, addr);
    exp_rdata = 32'h0;
    exp_word  = 32'h0;
    exp_rd    = 0;
    exp_wr    = 0;
    if (exp_err) exp_lat = 1;
    else if (!wr) begin
      exp_lat = 2; exp_rd = 1;
      exp_rdata = model_load(size, uns, addr);
    end else begin
      exp_word = model_store(size, addr, wdata);
      exp_wr = 1;
      if (size == 2'b10) exp_lat = 2;
      else begin exp_lat = 3; exp_rd = 1; end
    end

    @(negedge clk);
    checkOutput("ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = wr; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    lat = 0; got = 1'b0; got_err = 1'b0; got_rdata = 32'h0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) checkOutput("ready_busy", {31'h0, req_ready}, 32'h0);
      if (resp_valid) begin
        got = 1'b1; got_err = resp_err; got_rdata = resp_rdata;
      end
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("resp_err", {31'h0, got_err}, {31'h0, exp_err});
    checkOutput("resp_rdata", got_rdata, exp_rdata);
    @(negedge clk);
    checkOutput("resp_once", {31'h0, resp_valid}, 32'h0);
    checkOutput("ready_back", {31'h0, req_ready}, 32'h1);
    checkOutput("rd_pulses", 32'(rd_cnt - rd0), 32'(exp_rd));
    checkOutput("wr_pulses", 32'(wr_cnt - wr0), 32'(exp_wr));
    if (exp_wr == 1) begin
      checkOutput("wr_addr", last_wr_addr, addr & 32'hFFFF_FFFC);
      checkOutput("wr_data", last_wr_data, exp_word);
      ref_mem[addr / 4] = exp_word;
      checkOutput("mem_word", mem_arr[addr / 4], exp_word);
    end
  endtask

  task automatic resetDuringWrite();
    int wr0;
    int rv0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01;
    req_unsigned = 1'b0; req_addr = 32'h4; req_wdata = 32'h1234;
    wr0 = wr_cnt; rv0 = resp_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_wr_low", {31'h0, mem_write}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    checkOutput("rst_rdata", resp_rdata, 32'h0);
    checkOutput("rst_memctl", {30'h0, mem_read, mem_write}, 32'h0);
    checkOutput("rst_maddr", mem_addr, 32'h0);
    checkOutput("rst_mwdata", mem_wdata, 32'h0);
    checkOutput("rst_no_write", 32'(wr_cnt - wr0), 32'h0);
    checkOutput("rst_no_resp", 32'(resp_cnt - rv0), 32'h0);
    checkOutput("rst_word1", mem_arr[1], ref_mem[1]);
    rst_n = 1'b1;
  endtask

  task automatic backToBack();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] data_q[$];
    int          t_q[$];
    int          first_ready;
    logic        second_taken;
    exp_a = model_load(2'b10, 1'b0, 32'h8);
    exp_b = model_load(2'b00, 1'b1, 32'h11);
    first_ready = 0;
    second_taken = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h8;
    @(posedge clk);
    #1 req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h11;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (resp_valid) begin t_q.push_back(c); data_q.push_back(resp_rdata); end
      if (req_ready && !second_taken) begin
        first_ready = c;
        second_taken = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b_first_ready", 32'(first_ready), 32'd3);
    checkOutput("b2b_resp_count", 32'(t_q.size()), 32'd2);
    if (t_q.size() == 2) begin
      checkOutput("b2b_spacing", 32'(t_q[1] - t_q[0]), 32'd3);
      checkOutput("b2b_data_a", data_q[0], exp_a);
      checkOutput("b2b_data_b", data_q[1], exp_b);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("reset_ctl", {28'h0, resp_valid, resp_err, mem_read, mem_write}, 32'h0);
    checkOutput("reset_rdata", resp_rdata, 32'h0);
    checkOutput("reset_maddr", mem_addr, 32'h0);
    checkOutput("reset_mwdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AA);
    checkOutput("sb_word2", mem_arr[2], 32'hDEADAAEF);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h6, 32'h12345678);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h7E, 32'hCAFE);
    resetDuringWrite();
    backToBack();

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = 32'($urandom_range(0, MEM_WORDS * 4 + 7));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = a & 32'hFFFF_FFFE;
        if (sz == 2'b10) a = a & 32'hFFFF_FFFC;
      end
      applyStimulus(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
